minhash_topk_sorter: RTL and testbench

- Sorter stage between the hasher and the extender.
- Consumes one signature_index_pack per accepted beat from the hasher; each pack holds a kmer signature and its position in the fragment.
- Keeps the HASHER_EXTENDER_INDICES_COUNT smallest signatures of the current fragment in ascending order.
- At end of fragment, hands their indices to the extender as one bundle, then clears for the next fragment.

---
 rtl/proj_pkg.sv | 33 +++
 rtl/minhash_sorter_slot.sv | 52 +++++
 rtl/minhash_topk_sorter.sv | 122 ++++++++++++
 tb/tb_minhash_topk_sorter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// Shared sizing constants and types for the hasher -> sorter -> extender path.
package proj_pkg;

  localparam int unsigned HASHER_EXTENDER_INDICES_COUNT = 4;
  localparam int unsigned HASHER_SORTER_SIGNATURE       = 32;
  localparam int unsigned SORTER_INDICE_LEN             = 8;
  localparam int unsigned HASHER_EXTENDER_INDICE_LEN    = 9;

  localparam int unsigned SORTER_TOPK = HASHER_EXTENDER_INDICES_COUNT;
  localparam int unsigned SORTER_CNT_W = $clog2(SORTER_TOPK + 1);

  // Beat from the hasher: signature in the upper bits, fragment position below.
  typedef struct packed {
    logic [HASHER_SORTER_SIGNATURE-1:0] sig;
    logic [SORTER_INDICE_LEN-1:0]       idx;
  } signature_index_pack;

  typedef struct packed {
    logic                vld;
    signature_index_pack pack;
  } sorter_slot_t;

  typedef struct packed {
    logic [SORTER_CNT_W-1:0]                                    count;
    logic [SORTER_TOPK-1:0][HASHER_EXTENDER_INDICE_LEN-1:0]     indices;
  } sorter_out_pack;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } sorter_state_t;

endpackage

// File: rtl/minhash_sorter_slot.sv
// One entry of the sorted top-K list. It reports whether it stays put for an
// incoming signature (valid and sig <= incoming) and, on an insert, either
// holds, takes the entry of the slot below it, or takes the new beat.
module minhash_sorter_slot #(
  parameter int unsigned SIG_W = 32,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ins,
  input  logic             clr,
  input  logic [SIG_W-1:0] in_sig,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             nb_vld,
  input  logic [SIG_W-1:0] nb_sig,
  input  logic [IDX_W-1:0] nb_idx,
  input  logic             nb_le,
  output logic             vld,
  output logic [SIG_W-1:0] sig,
  output logic [IDX_W-1:0] idx,
  output logic             le
);

  // Stay-put flag; using <= keeps equal signatures in arrival order.
  always_comb begin
    le = vld && (sig <= in_sig);
  end

  // Hold / shift-up / load-new selection on an accepted beat.
  // The first slot that does not stay put while its lower neighbour does is the
  // insertion point; everything above it shifts up by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      sig <= '0;
      idx <= '0;
    end else if (clr) begin
      vld <= 1'b0;
    end else if (ins && !le) begin
      if (nb_le) begin
        vld <= 1'b1;
        sig <= in_sig;
        idx <= in_idx;
      end else begin
        vld <= nb_vld;
        sig <= nb_sig;
        idx <= nb_idx;
      end
    end
  end

endmodule

// File: rtl/minhash_topk_sorter.sv
// Sorter stage between hasher and extender: keeps the K smallest signatures of
// a fragment in ascending order and hands their indices over as one bundle.
module minhash_topk_sorter
  import proj_pkg::*;
#(
  parameter int unsigned K         = proj_pkg::HASHER_EXTENDER_INDICES_COUNT,
  parameter int unsigned SIG_W     = proj_pkg::HASHER_SORTER_SIGNATURE,
  parameter int unsigned IDX_W     = proj_pkg::SORTER_INDICE_LEN,
  parameter int unsigned OUT_IDX_W = proj_pkg::HASHER_EXTENDER_INDICE_LEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIG_W+IDX_W-1:0]     in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [K*OUT_IDX_W-1:0]     out_indices,
  output logic [$clog2(K+1)-1:0]     out_count
);

  localparam int unsigned CNT_W = $clog2(K + 1);

  sorter_state_t    state;
  sorter_state_t    state_nxt;
  logic             rdy;
  logic             accept;
  logic             release_bundle;
  logic [SIG_W-1:0] in_sig;
  logic [IDX_W-1:0] in_idx;

  logic             slot_vld [K];
  logic [SIG_W-1:0] slot_sig [K];
  logic [IDX_W-1:0] slot_idx [K];
  logic             slot_le  [K];
  logic             nb_vld   [K];
  logic [SIG_W-1:0] nb_sig   [K];
  logic [IDX_W-1:0] nb_idx   [K];
  logic             nb_le    [K];

  assign in_sig         = in_data[IDX_W +: SIG_W];
  assign in_idx         = in_data[IDX_W-1:0];
  assign in_ready       = rdy;
  assign out_valid      = (state == ST_EMIT);
  assign accept         = in_valid && rdy && (state == ST_COLLECT);
  assign release_bundle = (state == ST_EMIT) && out_ready;

  // Neighbour wiring: slot 0 sees a virtual always-stay neighbour so it loads
  // the new beat whenever it does not stay put itself.
  always_comb begin
    nb_vld[0] = 1'b0;
    nb_sig[0] = '0;
    nb_idx[0] = '0;
    nb_le[0]  = 1'b1;
    for (int unsigned i = 1; i < K; i++) begin
      nb_vld[i] = slot_vld[i-1];
      nb_sig[i] = slot_sig[i-1];
      nb_idx[i] = slot_idx[i-1];
      nb_le[i]  = slot_le[i-1];
    end
  end

  for (genvar g = 0; g < K; g++) begin : g_slot
    minhash_sorter_slot #(
      .SIG_W (SIG_W),
      .IDX_W (IDX_W)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .ins    (accept),
      .clr    (release_bundle),
      .in_sig (in_sig),
      .in_idx (in_idx),
      .nb_vld (nb_vld[g]),
      .nb_sig (nb_sig[g]),
      .nb_idx (nb_idx[g]),
      .nb_le  (nb_le[g]),
      .vld    (slot_vld[g]),
      .sig    (slot_sig[g]),
      .idx    (slot_idx[g]),
      .le     (slot_le[g])
    );
  end

  // Two-state flow: collect until the last beat, then emit until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT: if (accept && in_last) state_nxt = ST_EMIT;
      ST_EMIT:    if (out_ready)         state_nxt = ST_COLLECT;
      default:                           state_nxt = ST_COLLECT;
    endcase
  end

  // State and a registered ready, so ready only rises after reset release and
  // one cycle after a bundle is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_COLLECT;
      rdy   <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy   <= (state_nxt == ST_COLLECT);
    end
  end

  // Bundle view: zero-extended indices of valid slots, invalid slots as 0.
  always_comb begin
    out_indices = '0;
    out_count   = '0;
    if (state == ST_EMIT) begin
      for (int unsigned i = 0; i < K; i++) begin
        if (slot_vld[i]) begin
          out_indices[i*OUT_IDX_W +: OUT_IDX_W] = OUT_IDX_W'(slot_idx[i]);
          out_count = out_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_minhash_topk_sorter.sv
// Self-checking bench for minhash_topk_sorter: fixed vectors, hand-written
// backpressure/reset sequences and randomized fragments against a model.
module tb_minhash_topk_sorter;

  localparam int K = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_indices;
  logic [2:0]  out_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          n;
    logic [31:0] sig [6];
    logic [7:0]  idx [6];
    logic [35:0] exp_idx;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [4];

  logic [31:0] q_sig [$];
  logic [7:0]  q_idx [$];

  minhash_topk_sorter #(
    .K         (4),
    .SIG_W     (32),
    .IDX_W     (8),
    .OUT_IDX_W (9)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_indices (out_indices),
    .out_count   (out_count)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] pack4(input int a, input int b, input int c, input int d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one beat at a negedge; it is taken on the following posedge.
  task automatic beat(input logic [31:0] s, input logic [7:0] ix, input logic l);
    in_valid = 1'b1;
    in_data  = {s, ix};
    in_last  = l;
    chk("in_ready_collect", 64'(in_ready), 64'd1);
    @(negedge clk);
  endtask

  // Called at the negedge right after the last beat was taken.
  task automatic take_bundle(input string name, input logic [35:0] ei, input int ec, input int hold);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_idx"},   64'(out_indices), 64'(ei));
    chk({name, "_cnt"},   64'(out_count), 64'(ec));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_hold_ready"}, 64'(in_ready), 64'd0);
      chk({name, "_hold_idx"},   64'(out_indices), 64'(ei));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_drop_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  // Reference: pick the K smallest signatures, earliest arrival wins ties.
  task automatic model(output logic [35:0] ei, output int ec);
    bit taken [];
    int best;
    ei = '0;
    ec = (q_sig.size() < K) ? q_sig.size() : K;
    taken = new[q_sig.size()];
    for (int k = 0; k < ec; k++) begin
      best = -1;
      for (int j = 0; j < q_sig.size(); j++)
        if (!taken[j] && (best < 0 || q_sig[j] < q_sig[best])) best = j;
      taken[best] = 1'b1;
      ei[k*9 +: 9] = {1'b0, q_idx[best]};
    end
  endtask

  initial begin
    logic [35:0] ei;
    int          ec;
    logic [31:0] s;
    logic [7:0]  ix;
    int          n;
    int          mode;

    vecs[0].n = 5; vecs[0].sig = '{50, 10, 40, 20, 30, 0}; vecs[0].idx = '{0, 1, 2, 3, 4, 0};
    vecs[0].exp_idx = pack4(1, 3, 4, 2); vecs[0].exp_cnt = 4;
    vecs[1].n = 2; vecs[1].sig = '{7, 3, 0, 0, 0, 0};      vecs[1].idx = '{5, 6, 0, 0, 0, 0};
    vecs[1].exp_idx = pack4(6, 5, 0, 0); vecs[1].exp_cnt = 2;
    vecs[2].n = 5; vecs[2].sig = '{5, 5, 9, 5, 1, 0};      vecs[2].idx = '{1, 2, 3, 4, 5, 0};
    vecs[2].exp_idx = pack4(5, 1, 2, 4); vecs[2].exp_cnt = 4;
    vecs[3].n = 6; vecs[3].sig = '{6, 5, 4, 3, 2, 1};      vecs[3].idx = '{0, 1, 2, 3, 4, 5};
    vecs[3].exp_idx = pack4(5, 4, 3, 2); vecs[3].exp_cnt = 4;

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_idx",   64'(out_indices), 64'd0);
    chk("rst_cnt",   64'(out_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd1);

    // Fixed vectors, beats back-to-back.
    for (int v = 0; v < 4; v++) begin
      for (int b = 0; b < vecs[v].n; b++)
        beat(vecs[v].sig[b], vecs[v].idx[b], b == vecs[v].n - 1);
      take_bundle($sformatf("vec%0d", v), vecs[v].exp_idx, vecs[v].exp_cnt, 0);
    end

    // Backpressure with a waiting beat, then a single-beat 0xFFFFFFFF fragment.
    for (int b = 0; b < vecs[0].n; b++)
      beat(vecs[0].sig[b], vecs[0].idx[b], b == vecs[0].n - 1);
    in_valid = 1'b1; in_data = {32'hFFFF_FFFF, 8'd3}; in_last = 1'b1;
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_idx",   64'(out_indices), 64'(vecs[0].exp_idx));
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_idx",   64'(out_indices), 64'(vecs[0].exp_idx));
      chk("bp_hold_cnt",   64'(out_count), 64'd4);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_bubble_valid", 64'(out_valid), 64'd0);
    chk("bp_bubble_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    take_bundle("bp_next", pack4(3, 0, 0, 0), 1, 0);

    // Reset mid-fragment.
    beat(100, 1, 1'b0); beat(200, 2, 1'b0); beat(300, 3, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Reset mid-EMIT.
    beat(11, 7, 1'b0); beat(12, 9, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("rstemit_pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstemit_valid", 64'(out_valid), 64'd0);
    chk("rstemit_cnt",   64'(out_count), 64'd0);
    chk("rstemit_idx",   64'(out_indices), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstemit_ready", 64'(in_ready), 64'd1);
    beat(8, 2, 1'b1);
    take_bundle("post_rst", pack4(2, 0, 0, 0), 1, 0);

    // Randomized fragments with gaps, stray in_last and random backpressure.
    for (int f = 0; f < 40; f++) begin
      q_sig.delete(); q_idx.delete();
      n = $urandom_range(1, 8);
      mode = $urandom_range(0, 2);
      for (int b = 0; b < n; b++) begin
        case (mode)
          0:       s = $urandom;
          1:       s = 32'($urandom_range(0, 7));
          default: s = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
        endcase
        ix = 8'($urandom_range(0, 255));
        q_sig.push_back(s); q_idx.push_back(ix);
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          in_last  = ($urandom_range(0, 1) != 0);
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        beat(s, ix, b == n - 1);
      end
      model(ei, ec);
      take_bundle($sformatf("rand%0d", f), ei, ec, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
